// File: rtl/sub_div_sequencer.sv
// Unsigned 9-bit divider by repeated subtraction on one shared ripple subtractor.
// Quotient counts successful subtractions until the subtractor reports a borrow.
module ripple_sub_9bit (
    input  logic [8:0] i_x,
    input  logic [8:0] i_y,
    output logic [8:0] o_diff,
    output logic       o_borrow
);
    logic [9:0] w_b;

    assign w_b[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_bit
            assign o_diff[gi] = i_x[gi] ^ i_y[gi] ^ w_b[gi];
            assign w_b[gi+1]  = (~i_x[gi] & i_y[gi]) |
                                (~(i_x[gi] ^ i_y[gi]) & w_b[gi]);
        end
    endgenerate

    assign o_borrow = w_b[9];
endmodule

module sub_div_sequencer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_quo;
    logic             r_dbz;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic             w_accept;
    logic             w_zero_div;

    ripple_sub_9bit u_sub (
        .i_x      (r_rem),
        .i_y      (r_div),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_zero_div = (divisor == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_zero_div ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_borrow) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    // Results stay put outside RUN so they remain valid after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_div <= '0;
            r_quo <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_rem <= dividend;
            r_quo <= '0;
            r_dbz <= w_zero_div;
            if (!w_zero_div) begin
                r_div <= divisor;
            end
        end else if (r_state == S_RUN && !w_borrow) begin
            r_rem <= w_diff;
            r_quo <= r_quo + 9'd1;
        end
    end

    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_sub_div_sequencer.sv
// Directed bench for sub_div_sequencer: vector table plus
// hand sequences for busy-start, held start and mid-run reset.
module tb_sub_div_sequencer;
    logic       clk;
    logic       rst;
    logic       start;
    logic [8:0] dividend;
    logic [8:0] divisor;
    logic       busy;
    logic       done;
    logic [8:0] quotient;
    logic [8:0] remainder;
    logic       div_by_zero;

    int n_cmp;
    int n_bad;

    sub_div_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] a;
        logic [8:0] b;
        logic [8:0] q;
        logic [8:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // lat = edges after the accepting edge until done is first seen high
    task automatic run_op(input logic [8:0] a, input logic [8:0] b,
                          input logic [8:0] q, input logic [8:0] r,
                          input logic z, input int lat, input string tag);
        int k;
        logic busy_ok;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        k       = 0;
        busy_ok = 1'b1;
        while (!done && k < 600) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, " latency"}, k, lat);
        chk({tag, " busy"}, {31'd0, busy_ok & busy}, 1);
        chk({tag, " quotient"}, quotient, q);
        chk({tag, " remainder"}, remainder, r);
        chk({tag, " dbz"}, div_by_zero, z);
        @(posedge clk);
        #1;
        chk({tag, " done drop"}, done, 0);
        chk({tag, " idle"}, busy, 0);
    endtask

    initial begin
        int k;
        int seen;
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        vecs[0] = '{9'd100, 9'd7, 9'd14, 9'd2, 1'b0, 15};
        vecs[1] = '{9'd5, 9'd9, 9'd0, 9'd5, 1'b0, 1};
        vecs[2] = '{9'd9, 9'd9, 9'd1, 9'd0, 1'b0, 2};
        vecs[3] = '{9'd37, 9'd0, 9'd0, 9'd37, 1'b1, 0};
        vecs[4] = '{9'd511, 9'd1, 9'd511, 9'd0, 1'b0, 512};
        vecs[5] = '{9'd0, 9'd3, 9'd0, 9'd0, 1'b0, 1};
        vecs[6] = '{9'd255, 9'd16, 9'd15, 9'd15, 1'b0, 16};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset q", quotient, 0);
        chk("reset r", remainder, 0);
        chk("reset dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                   vecs[i].z, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // start pulsed during RUN must be ignored
        @(negedge clk);
        dividend = 9'd200;
        divisor  = 9'd10;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        dividend = 9'd50;
        divisor  = 9'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 4;
        while (!done && k < 600) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("busy-start latency", k, 21);
        chk("busy-start q", quotient, 20);
        chk("busy-start r", remainder, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("busy-start no 2nd done", seen, 0);
        chk("busy-start q held", quotient, 20);

        // start held high: one IDLE cycle between operations
        @(negedge clk);
        dividend = 9'd9;
        divisor  = 9'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) @(posedge clk);
        #1;
        chk("held done", done, 1);
        chk("held q", quotient, 3);
        @(posedge clk);
        #1;
        chk("held idle gap", busy, 0);
        @(posedge clk);
        #1;
        chk("held reaccept", busy, 1);
        chk("held q cleared", quotient, 0);
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("held 2nd idle", busy, 0);

        // async reset mid-RUN aborts without done
        @(negedge clk);
        dividend = 9'd300;
        divisor  = 9'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        chk("pre-reset q", quotient, 50);
        rst = 1'b1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort q", quotient, 0);
        chk("abort r", remainder, 0);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("abort no done", seen, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(9'd17, 9'd4, 9'd4, 9'd1, 1'b0, 5, "after-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
